// File: rtl/in_stage_pkg.sv
// Shared constants and state encoding for the packet-assembly stage and its
// downstream serialiser.
package in_stage_pkg;

  localparam int PKT_LEN = 188;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;

  // Terminal packet address, also used by out_stage as its wrap point.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PKT_LEN - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/in_stage_pp_ram.sv
// Two-bank ping-pong packet RAM: one write port and one registered read port,
// with each bank addressed by {bank, addr}.
module in_stage_pp_ram
  import in_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              wr_bank_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_bank_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [0:1][0:PKT_LEN-1];
  logic [DATA_W-1:0] rd_data_q;

  // Write port; the writer never produces an address beyond LAST_ADDR.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_bank_i][wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read.  A read and a write to the same location in one cycle return the old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_addr_i <= LAST_ADDR) begin
      rd_data_q <= mem_q[rd_bank_i][rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/in_stage.sv
// Packet-assembly stage: collects PKT_LEN-byte packets into a ping-pong RAM and
// flags complete and abandoned packets to the downstream serialiser.
module in_stage
  import in_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              Valid_in,
  input  logic              Sop_in,
  input  logic [DATA_W-1:0] In_byte,
  input  logic              RE,
  input  logic [ADDR_W-1:0] RdAdd,
  output logic [DATA_W-1:0] Rd_byte,
  output logic              DONE,
  output logic              WrBank,
  output logic              Pkt_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              done_q, done_d;
  logic              pkt_err_q, pkt_err_d;
  logic              we_s;
  logic [ADDR_W-1:0] wr_addr_s;

  // State register.  After reset the writer starts on bank 1 because the reader starts on bank 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b1;
      done_q    <= 1'b0;
      pkt_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      done_q    <= done_d;
      pkt_err_q <= pkt_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Valid_in && Sop_in) begin
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (Valid_in && !Sop_in && (wr_cnt_q == LAST_ADDR)) begin
          state_d = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port control, counter, bank toggle and pulse generation
  always_comb begin
    we_s      = 1'b0;
    wr_addr_s = wr_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    done_d    = 1'b0;
    pkt_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Valid_in && Sop_in) begin
          we_s      = 1'b1;
          wr_addr_s = '0;
          wr_cnt_d  = ADDR_W'(1);
        end else begin
          wr_cnt_d  = '0;
        end
      end
      FILL: begin
        if (Valid_in && Sop_in) begin
          // A new start-of-packet abandons the partial packet and restarts it in the same bank.
          we_s      = 1'b1;
          wr_addr_s = '0;
          wr_cnt_d  = ADDR_W'(1);
          pkt_err_d = 1'b1;
        end else if (Valid_in) begin
          we_s = 1'b1;
          if (wr_cnt_q == LAST_ADDR) begin
            wr_cnt_d  = '0;
            wr_bank_d = ~wr_bank_q;
            done_d    = 1'b1;
          end else begin
            wr_cnt_d  = wr_cnt_q + ADDR_W'(1);
          end
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end
      default: begin
        wr_cnt_d = '0;
      end
    endcase
  end

  in_stage_pp_ram u_pp_ram (
    .clk       (clk),
    .rst       (reset),
    .we_i      (we_s),
    .wr_bank_i (wr_bank_q),
    .wr_addr_i (wr_addr_s),
    .wr_data_i (In_byte),
    .rd_bank_i (RE),
    .rd_addr_i (RdAdd),
    .rd_data_o (Rd_byte)
  );

  assign DONE    = done_q;
  assign WrBank  = wr_bank_q;
  assign Pkt_err = pkt_err_q;

endmodule

// File: tb/tb_in_stage.sv
// Self-checking bench for in_stage.  It runs table-driven packet scenarios,
// a concurrent ping-pong read/write stream, and a reset applied mid-packet.
module tb_in_stage;
  import in_stage_pkg::*;

  logic       clk = 1'b0;
  logic       reset, valid, sop, re;
  logic [7:0] in_byte, rdadd;
  wire  [7:0] rd_byte;
  wire        done, wrbank, pkt_err;

  always #5 clk = ~clk;

  in_stage dut (
    .clk      (clk),
    .reset    (reset),
    .Valid_in (valid),
    .Sop_in   (sop),
    .In_byte  (in_byte),
    .RE       (re),
    .RdAdd    (rdadd),
    .Rd_byte  (rd_byte),
    .DONE     (done),
    .WrBank   (wrbank),
    .Pkt_err  (pkt_err)
  );

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] ref_mem [0:1][0:PKT_LEN-1];
  logic       exp_bank;
  logic [7:0] sb_q [$];

  typedef struct {
    int         junk;
    int         abort_at;
    int         gap;
    logic [7:0] seed;
    int         exp_done;
    int         exp_err;
  } vec_t;
  vec_t vecs [4];

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (pkt_err === 1'b1) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One input cycle, followed by checks on the pulses and the write bank.
  task automatic send(input logic v, input logic s, input logic [7:0] d,
                      input logic e_done, input logic e_err);
    valid   = v;
    sop     = s;
    in_byte = d;
    cyc();
    valid = 1'b0;
    sop   = 1'b0;
    if (e_done) exp_bank = ~exp_bank;
    chk("done", 32'(done), 32'(e_done));
    chk("pkt_err", 32'(pkt_err), 32'(e_err));
    chk("wrbank", 32'(wrbank), 32'(exp_bank));
    if (e_done) re = ~re;
  endtask

  task automatic send_pkt(input logic [7:0] seed, input int nbytes, input int gap, input bit err_first);
    logic [7:0] d;
    for (int i = 0; i < nbytes; i++) begin
      d = (i == 0) ? 8'h47 : (8'(i) + seed);
      ref_mem[exp_bank][i] = d;
      send(1'b1, i == 0, d, i == PKT_LEN - 1, err_first && (i == 0));
      for (int g = 0; g < gap; g++) send(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic read_bank(input string name);
    logic [7:0] e;
    for (int i = 0; i < PKT_LEN; i++) begin
      rdadd = 8'(i);
      sb_q.push_back(ref_mem[re][i]);
      cyc();
      e = sb_q.pop_front();
      chk(name, 32'(rd_byte), 32'(e));
    end
  endtask

  initial begin
    int d0, e0;
    vecs[0] = '{0,  -1,  0, 8'h00, 1, 0};
    vecs[1] = '{10, -1,  0, 8'h30, 1, 0};
    vecs[2] = '{0,  100, 0, 8'h81, 1, 1};
    vecs[3] = '{0,  -1,  2, 8'hC3, 1, 0};

    reset = 1'b1; valid = 1'b0; sop = 1'b0; in_byte = 8'h00; re = 1'b0; rdadd = 8'h00;
    exp_bank = 1'b1;
    repeat (3) cyc();
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_pkt_err", 32'(pkt_err), 32'd0);
    chk("reset_wrbank", 32'(wrbank), 32'd1);
    chk("reset_rd_byte", 32'(rd_byte), 32'd0);
    reset = 1'b0;
    cyc();

    for (int k = 0; k < 4; k++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      for (int j = 0; j < vecs[k].junk; j++) send(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
      if (vecs[k].abort_at >= 0) send_pkt(vecs[k].seed ^ 8'h3C, vecs[k].abort_at, vecs[k].gap, 1'b0);
      send_pkt(vecs[k].seed, PKT_LEN, vecs[k].gap, vecs[k].abort_at >= 0);
      repeat (2) send(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk($sformatf("done_count%0d", k), 32'(done_cnt - d0), 32'(vecs[k].exp_done));
      chk($sformatf("err_count%0d", k), 32'(err_cnt - e0), 32'(vecs[k].exp_err));
      if (k == 0) begin
        rdadd = 8'd5;
        cyc();
        chk("first_pkt_addr5", 32'(rd_byte), 32'd5);
      end
      read_bank($sformatf("readback%0d", k));
    end

    // Packet A is read out while packet B fills the opposite bank.
    send_pkt(8'hA0, PKT_LEN, 0, 1'b0);
    fork
      read_bank("streamA");
      send_pkt(8'h5A, PKT_LEN, 1, 1'b0);
    join
    read_bank("streamB");

    // Reset arrives partway through a packet being written into bank 0.
    send_pkt(8'h22, PKT_LEN, 0, 1'b0);
    rdadd = 8'd5;
    send_pkt(8'h11, 150, 0, 1'b0);
    chk("pre_reset_rd_byte", 32'(rd_byte), 32'(ref_mem[re][5]));
    chk("pre_reset_wrbank", 32'(wrbank), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_reset_done", 32'(done), 32'd0);
    chk("mid_reset_pkt_err", 32'(pkt_err), 32'd0);
    chk("mid_reset_rd_byte", 32'(rd_byte), 32'd0);
    chk("mid_reset_wrbank", 32'(wrbank), 32'd1);
    re = 1'b0;
    exp_bank = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    send_pkt(8'h77, PKT_LEN, 0, 1'b0);
    chk("post_reset_re", 32'(re), 32'd1);
    read_bank("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
